// File: rtl/cpld_host_bridge.sv
// Clocked CPU-to-BBC host bus bridge: qualifies accesses, runs a req/ack host
// cycle with CPU stall, and commits paged-ROM / shadow register writes on ack.
module cpld_host_bridge #(
  parameter int ADR_W     = 16,
  parameter int BBC_ADR_W = 12,
  parameter int ROMSEL_W  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           j,
  input  logic [ADR_W-1:0]     cpu_adr,
  input  logic [7:0]           cpu_data,
  input  logic                 cpu_rnw,
  input  logic                 cpu_vld,
  input  logic                 host_ack,
  output logic                 host_req,
  output logic [BBC_ADR_W-1:0] bbc_adr,
  output logic                 cpu_stall,
  output logic [ROMSEL_W-1:0]  romsel,
  output logic                 shadow_en,
  output logic                 dec_fe4x,
  output logic                 err
);

  // state   | meaning
  // IDLE    | waiting for a host-page access
  // REQ     | host_req asserted, waiting for host_ack or timeout
  // RELEASE | host_req dropped, waiting for host_ack to fall
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rnw_q;
  logic [7:0]       data_q;
  logic             rom_q, shadow_q;
  logic             bank_zero, host_hit, rom_hit, shadow_hit, fe4x_hit;
  logic             accept, commit, tc;
  logic             unused_data;

  generate
    if (ADR_W > 16) begin : g_bank
      assign bank_zero = (cpu_adr[ADR_W-1:16] == '0);
    end else begin : g_nobank
      assign bank_zero = 1'b1;
    end
  endgenerate

  assign host_hit   = cpu_vld && bank_zero &&
                      (cpu_adr[15:8] == 8'hFC || cpu_adr[15:8] == 8'hFD ||
                       cpu_adr[15:8] == 8'hFE);
  assign rom_hit    = (j == 2'b10) ? (cpu_adr[15:0] == 16'hFE05)
                                   : (cpu_adr[15:0] == 16'hFE30);
  assign shadow_hit = (j == 2'b01) && (cpu_adr[15:0] == 16'hFE34);
  assign fe4x_hit   = (cpu_adr[15:4] == 12'hFE4);

  assign tc          = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign accept      = (state_q == IDLE) && host_hit;
  assign commit      = (state_q == REQ) && host_ack && !rnw_q;
  assign unused_data = ^data_q;

  always_comb begin
    state_d   = state_q;
    host_req  = 1'b0;
    cpu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_hit) state_d = REQ;
      end
      REQ: begin
        host_req  = 1'b1;
        cpu_stall = 1'b1;
        if (host_ack || tc) state_d = RELEASE;
      end
      RELEASE: begin
        cpu_stall = 1'b1;
        if (!host_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rnw_q     <= 1'b1;
      data_q    <= '0;
      rom_q     <= 1'b0;
      shadow_q  <= 1'b0;
      bbc_adr   <= '0;
      romsel    <= '0;
      shadow_en <= 1'b0;
      dec_fe4x  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == REQ) ? cnt_q + 1'b1 : '0;
      // Decode is frozen here so a jumper change mid-cycle cannot retarget the commit.
      if (accept) begin
        bbc_adr  <= cpu_adr[BBC_ADR_W-1:0];
        rnw_q    <= cpu_rnw;
        data_q   <= cpu_data;
        rom_q    <= rom_hit;
        shadow_q <= shadow_hit;
        dec_fe4x <= fe4x_hit;
      end
      if (commit) begin
        if (rom_q)    romsel    <= data_q[ROMSEL_W-1:0];
        if (shadow_q) shadow_en <= data_q[7];
      end
      if ((state_q == REQ) && !host_ack && tc) err <= 1'b1;
    end
  end

endmodule

// File: doc/cpld_host_bridge.md
Name: cpld_host_bridge

Overview:
- Clocked successor to the combinational address latch/decoder in the CPLD.
- Qualifies each CPU access and decodes mode-dependent host registers (ROM select, B+ shadow, FE4x).
- Runs a 4-phase request/acknowledge handshake to the BBC host bus for I/O-page cycles, stalling the CPU meanwhile.
- Commits paged-ROM and shadow-RAM register writes only when a host cycle completes; widened to 24-bit 65816 addresses, with a timeout and an error flag.

Parameters:
- ADR_W, 16: CPU address width; legal 16..24; bits above 15 are the bank and must be zero for a host hit.
- BBC_ADR_W, 12: width of the latched host address (cpu_adr[BBC_ADR_W-1:0]).
- ROMSEL_W, 4: width of the captured paged-ROM select (cpu_data[ROMSEL_W-1:0]).
- TIMEOUT, 255: cycles in REQ without host_ack before the cycle is abandoned; minimum 2.

Ports:
- clk  in  1  CPU-side clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- j  in  2  mode jumpers: 00 beeb, 01 bplus, 10 elk, 11 master; sampled every cycle.
- cpu_adr  in  ADR_W  CPU address; valid when cpu_vld=1.
- cpu_data  in  8  CPU write data; valid with cpu_vld on writes.
- cpu_rnw  in  1  1=read, 0=write.
- cpu_vld  in  1  one-cycle access strobe.
- host_ack  in  1  host handshake acknowledge.
- host_req  out  1  host cycle request.
- bbc_adr  out  BBC_ADR_W  latched host address.
- cpu_stall  out  1  holds the CPU while a host cycle is outstanding.
- romsel  out  ROMSEL_W  committed paged-ROM select.
- shadow_en  out  1  committed B+ shadow enable (cpu_data[7]).
- dec_fe4x  out  1  registered: the last accepted host cycle targeted FE40-FE4F.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timeout counter 0. Reset mid-cycle drops to IDLE at once and discards any pending commit.
- Host hit: cpu_vld=1 AND cpu_adr[ADR_W-1:16]==0 (when ADR_W>16) AND cpu_adr[15:8] in {FC, FD, FE}.
- Register decode on the hit address:
  - rom_hit: elk mode ? adr==FE05 : adr==FE30.
  - shadow_hit: bplus mode AND adr==FE34.
  - fe4x_hit: adr[15:4]==FE4.
- IDLE:
  - Host hit: latch bbc_adr, cpu_rnw, cpu_data[7:0], rom_hit, shadow_hit; load dec_fe4x; go to REQ.
  - host_req=1 and cpu_stall=1 from the next cycle, i.e. 1-cycle latency from cpu_vld.
  - Non-hit accesses are ignored; no output changes.
- REQ:
  - host_req=1, cpu_stall=1; counter increments each cycle.
  - host_ack=1: go to RELEASE. If the latched access was a write, commit in that same edge: rom_hit loads romsel; shadow_hit loads shadow_en.
  - Counter reaches TIMEOUT-1 with host_ack still 0: set err, no commit, go to RELEASE.
  - Simultaneous ack and timeout: ack wins, commit happens, err unchanged.
- RELEASE:
  - host_req=0; cpu_stall stays 1.
  - Stay while host_ack=1; when host_ack=0, go to IDLE with cpu_stall=0 and the counter cleared.
- cpu_vld outside IDLE is ignored; bbc_adr and latched data hold stable until the next accepted hit.
- Reads never change romsel or shadow_en.
- Mode change during a cycle: decode uses j as sampled at latch time.
- err clears only on rst.
- Back-to-back: a hit in the cycle IDLE is re-entered is accepted normally. Minimum cycle is 3 clocks with an immediate ack.

Test Plan:
- rst held 2 cycles, then released -> all outputs 0; cpu_vld read of 0x3000 -> no host_req, no stall.
- j=00: write 0x0B to FE30, host_ack raised 3 cycles after host_req, dropped 2 cycles later -> bbc_adr=0xE30, romsel=0xB in the ack edge, stall released the cycle after ack falls.
- j=10: write 0x05 to FE30 -> romsel unchanged; write 0x05 to FE05 -> romsel=0x5. j=01: write 0x80 to FE34 -> shadow_en=1; same write with j=00 -> shadow_en unchanged.
- host_ack never asserted, TIMEOUT=8 -> host_req falls after 8 REQ cycles, err=1, romsel unchanged, return to IDLE; next cycle acknowledged -> err stays 1.
- ADR_W=24: access 0x01FE30 -> ignored; access 0x00FE42 -> host cycle with dec_fe4x=1. A second cpu_vld during REQ -> ignored, bbc_adr unchanged.
- rst pulsed while in REQ on a FE30 write -> IDLE next cycle, host_req=0, romsel stays 0 after a late host_ack.
